interface_request_mux: RTL and testbench
========================================

Name: interface_request_mux

Overview:
N-to-1 request multiplexer for the SoC adapter layer. It sits directly downstream of the round-robin interface arbiter: it presents the masters' pending requests to the arbiter, consumes the returned select index, and locks the grant. It then forwards the winning master's request to a single slave port and routes the slave response back to that master. One transaction is outstanding at a time, and a response timeout protects masters from a dead slave.

Parameters:
IN_COUNT, 2, number of master ports
IN_COUNT_LOG, max(1,$clog2(IN_COUNT)), width of select index
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
TIMEOUT_CYCLES, 255, response timeout in cycles; 0 disables timeout

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
m_req_valid_i  in  IN_COUNT  per-master request valid
m_req_ready_o  out  IN_COUNT  per-master request accept (one-hot or zero)
m_addr_i  in  IN_COUNT*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
m_wdata_i  in  IN_COUNT*DATA_W  write data, same packing
m_we_i  in  IN_COUNT  write enable
m_be_i  in  IN_COUNT*DATA_W/8  byte enables, same packing
m_rsp_valid_o  out  IN_COUNT  per-master response strobe (one-hot or zero)
m_rdata_o  out  DATA_W  response data, shared by all masters
m_err_o  out  1  response error, shared
arb_valid_list_o  out  IN_COUNT  request vector presented to arbiter
arb_sel_i  in  IN_COUNT_LOG  arbiter select index
s_req_valid_o / s_req_ready_i  out/in  1  slave request handshake
s_addr_o, s_wdata_o, s_we_o, s_be_o  out  ADDR_W, DATA_W, 1, DATA_W/8  slave request fields
s_rsp_valid_i, s_rdata_i, s_err_i  in  1, DATA_W, 1  slave response

Behaviour:
- Reset (async): state IDLE; grant_r=0; latched request fields=0; counter=0. All outputs 0 during and after reset until an event occurs.
- FSM states: IDLE, REQ, RESP, FLUSH.
- IDLE:
  - arb_valid_list_o = m_req_valid_i. In every other state it is 0, so the arbiter advances exactly once per grant.
  - If |m_req_valid_i: m_req_ready_o[arb_sel_i]=1 (combinational). On that edge, grant_r<=arb_sel_i and addr/wdata/we/be of that master are latched; go to REQ.
  - If arb_sel_i indexes a master with valid low, no grant is made and the block stays in IDLE. This is a protocol error and the bench asserts on it.
- REQ:
  - s_req_valid_o=1, driven from latched fields only, so fields are stable under backpressure.
  - On s_req_valid_o & s_req_ready_i, go to RESP and clear the counter.
  - Latency: master accept in cycle 0, s_req_valid_o earliest in cycle 1.
- RESP:
  - If s_rsp_valid_i: m_rsp_valid_o[grant_r]=1, m_rdata_o=s_rdata_i, m_err_o=s_err_i in the same cycle (0-cycle passthrough); go to IDLE.
  - Otherwise the counter increments. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: m_rsp_valid_o[grant_r]=1, m_err_o=1, m_rdata_o=0; go to FLUSH. The timeout response occurs in the TIMEOUT_CYCLES-th RESP cycle.
  - If a response and expiry fall in the same cycle, the real response wins and no error is injected.
- FLUSH:
  - Swallows exactly one s_rsp_valid_i without forwarding it, then goes to IDLE.
  - Alternatively, a second full TIMEOUT_CYCLES period expires, then goes to IDLE.
  - No m_* outputs are asserted in FLUSH.
- m_rsp_valid_o / m_req_ready_o are zero outside the cases above. m_rdata_o and m_err_o are 0 when no response strobe is asserted.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.
- Reset mid-transaction: the in-flight transaction is dropped with no response to the master. The slave side is responsible for its own reset.
- IN_COUNT=1: arb_sel_i is ignored and grant is always 0.

Decomposition:
- Shared package adapter_pkg: state enum (IDLE, REQ, RESP, FLUSH) and a packed request struct {addr, wdata, we, be} parameterised by localparams ADDR_W_DEF=32, DATA_W_DEF=32.
- Sub-module: response_timer (counter, clear/enable inputs, expiry output, TIMEOUT_CYCLES parameter), used for both RESP and FLUSH timeouts.
- The arbiter stays external and is connected via arb_*.

Test Plan:
1. Single request: master0 read addr 0x1000, s_req_ready_i=1, response 3 cycles later with rdata 0xDEADBEEF -> m_req_ready_o=01 cycle 0; s_req_valid_o with addr 0x1000 cycle 1; m_rsp_valid_o=01 with rdata 0xDEADBEEF, err 0 in the same cycle as s_rsp_valid_i.
2. Both masters requesting continuously, arb_sel_i model sequence 1,0,1,0 -> slave sees master1, master0, master1, master0 addresses. Each response goes only to its owner. arb_valid_list_o is nonzero only in IDLE cycles.
3. Backpressure: s_req_ready_i low 5 cycles after grant to master1 (write 0xCAFEF00D, be 0xF) -> s_req_valid_o held 5 cycles with all fields stable; m_req_ready_o=0 throughout; master0 remains waiting.
4. Timeout TIMEOUT_CYCLES=8, no slave response -> in the 8th RESP cycle m_rsp_valid_o[grant]=1, m_err_o=1, m_rdata_o=0. A late response at RESP cycle 12 is swallowed in FLUSH and not forwarded. The next request completes normally.
5. With TIMEOUT_CYCLES=8, s_rsp_valid_i with s_err_i=0 exactly in the 8th RESP cycle -> real response forwarded, m_err_o=0, state returns to IDLE (no FLUSH).
6. reset_i pulsed asynchronously mid-cycle while in RESP -> all outputs 0 immediately. After release the state is IDLE and a new request is accepted with m_req_ready_o in the first cycle.

Source files
------------

// File: rtl/adapter_pkg.sv
// Shared types for the SoC adapter layer: the transaction FSM states and the
// default-width request bundle.
package adapter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
    logic                    we;
    logic [DATA_W_DEF/8-1:0] be;
  } req_t;

endpackage

// File: rtl/interface_request_mux_response_timer.sv
// Saturating cycle counter that flags the last cycle of a TIMEOUT_CYCLES-long
// wait. TIMEOUT_CYCLES == 0 disables expiry.
module response_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int EXP_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] EXP_VAL = EXP_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == EXP_VAL);

endmodule

// File: rtl/interface_request_mux.sv
// N-to-1 request mux behind an external arbiter: locks one grant, forwards the
// winner's request to the slave and steers the single response back.
module interface_request_mux
  import adapter_pkg::*;
#(
  parameter int IN_COUNT       = 2,
  parameter int IN_COUNT_LOG   = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [IN_COUNT-1:0]          m_req_valid_i,
  output logic [IN_COUNT-1:0]          m_req_ready_o,
  input  logic [IN_COUNT*ADDR_W-1:0]   m_addr_i,
  input  logic [IN_COUNT*DATA_W-1:0]   m_wdata_i,
  input  logic [IN_COUNT-1:0]          m_we_i,
  input  logic [IN_COUNT*DATA_W/8-1:0] m_be_i,
  output logic [IN_COUNT-1:0]          m_rsp_valid_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_err_o,
  output logic [IN_COUNT-1:0]          arb_valid_list_o,
  input  logic [IN_COUNT_LOG-1:0]      arb_sel_i,
  output logic                         s_req_valid_o,
  input  logic                         s_req_ready_i,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic                         s_we_o,
  output logic [DATA_W/8-1:0]          s_be_o,
  input  logic                         s_rsp_valid_i,
  input  logic [DATA_W-1:0]            s_rdata_i,
  input  logic                         s_err_i,
  output state_e                       dbg_state
);

  localparam int BE_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [BE_W-1:0]   be;
  } req_s;

  // Handshakes: a master request transfers when m_req_valid_i & m_req_ready_o,
  // the slave request when s_req_valid_o & s_req_ready_i; responses are
  // single-cycle strobes with no back-pressure.
  state_e                  state, state_next;
  logic [IN_COUNT_LOG-1:0] sel_idx, grant;
  logic [IN_COUNT-1:0]     sel_onehot, grant_onehot;
  logic                    sel_valid, accept;
  req_s                    sel_req, req;
  logic                    tmr_clear, tmr_enable, tmr_expired;

  assign sel_idx = (IN_COUNT == 1) ? '0 : arb_sel_i;

  always_comb begin
    sel_onehot   = '0;
    grant_onehot = '0;
    sel_req      = '0;
    for (int i = 0; i < IN_COUNT; i++) begin
      if (sel_idx == IN_COUNT_LOG'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_req.addr  = m_addr_i[i*ADDR_W +: ADDR_W];
        sel_req.wdata = m_wdata_i[i*DATA_W +: DATA_W];
        sel_req.we    = m_we_i[i];
        sel_req.be    = m_be_i[i*BE_W +: BE_W];
      end
      if (grant == IN_COUNT_LOG'(i)) begin
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // A select pointing at an idle master (or past the last one) grants nothing.
  assign sel_valid = |(sel_onehot & m_req_valid_i);

  always_comb begin
    state_next       = state;
    accept           = 1'b0;
    m_req_ready_o    = '0;
    arb_valid_list_o = '0;
    m_rsp_valid_o    = '0;
    m_rdata_o        = '0;
    m_err_o          = 1'b0;
    s_req_valid_o    = 1'b0;
    tmr_clear        = 1'b0;
    tmr_enable       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!reset_i) begin
          arb_valid_list_o = m_req_valid_i;
          if (sel_valid) begin
            accept        = 1'b1;
            m_req_ready_o = sel_onehot;
            state_next    = REQ;
          end
        end
      end
      REQ: begin
        s_req_valid_o = 1'b1;
        if (s_req_ready_i) begin
          tmr_clear  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        // A real response beats a timeout landing in the same cycle.
        if (s_rsp_valid_i) begin
          m_rsp_valid_o = grant_onehot;
          m_rdata_o     = s_rdata_i;
          m_err_o       = s_err_i;
          state_next    = IDLE;
        end else if (tmr_expired) begin
          m_rsp_valid_o = grant_onehot;
          m_err_o       = 1'b1;
          tmr_clear     = 1'b1;
          state_next    = FLUSH;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      FLUSH: begin
        if (s_rsp_valid_i || tmr_expired) begin
          state_next = IDLE;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      grant <= '0;
      req   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        grant <= sel_idx;
        req   <= sel_req;
      end
    end
  end

  response_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  assign s_addr_o  = req.addr;
  assign s_wdata_o = req.wdata;
  assign s_we_o    = req.we;
  assign s_be_o    = req.be;
  assign dbg_state = state;

endmodule

// File: tb/tb_interface_request_mux.sv
// Bench for interface_request_mux: the bench plays arbiter, masters and slave,
// and predicts every master/slave-side value from transaction-level rules.
module tb_interface_request_mux;
  import adapter_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 8;
  localparam int SW = AW + DW + 1 + BW;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [N-1:0]    m_req_valid, m_req_ready, m_we, m_rsp_valid, arb_valid_list;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*BW-1:0] m_be;
  logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
  logic            m_err, s_req_valid, s_req_ready, s_we, s_rsp_valid, s_err;
  logic [0:0]      arb_sel;
  logic [AW-1:0]   s_addr;
  logic [BW-1:0]   s_be;
  state_e          dbg_state;

  int errors = 0;
  int checks = 0;
  logic [SW-1:0] exp_q[$];

  // Per-master pending request, the arbiter's memory and the slave's plan.
  logic [AW-1:0] pa [N];
  logic [DW-1:0] pw [N];
  logic          pwe[N];
  logic [BW-1:0] pbe[N];
  logic          pv [N];
  int            last_grant;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  interface_request_mux #(
    .IN_COUNT(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_req_valid_i(m_req_valid), .m_req_ready_o(m_req_ready),
    .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_we_i(m_we), .m_be_i(m_be),
    .m_rsp_valid_o(m_rsp_valid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .arb_valid_list_o(arb_valid_list), .arb_sel_i(arb_sel),
    .s_req_valid_o(s_req_valid), .s_req_ready_i(s_req_ready),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_we_o(s_we), .s_be_o(s_be),
    .s_rsp_valid_i(s_rsp_valid), .s_rdata_i(s_rdata), .s_err_i(s_err),
    .dbg_state(dbg_state)
  );

  // The arbiter must never select an idle master while any master requests.
  always @(negedge clk) begin
    if (!reset_i && dbg_state == IDLE && (|m_req_valid))
      assert (m_req_valid[arb_sel]) else $error("protocol error: arb_sel selects an idle master");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  task automatic check_quiet_rsp(input string tag);
    check({tag, "_rsp_valid"}, m_rsp_valid, 0);
    check({tag, "_rdata"}, m_rdata, 0);
    check({tag, "_err"}, m_err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet_rsp(tag);
    check({tag, "_req_ready"}, m_req_ready, 0);
    check({tag, "_arb_list"}, arb_valid_list, 0);
    check({tag, "_s_valid"}, s_req_valid, 0);
    check({tag, "_s_addr"}, s_addr, 0);
    check({tag, "_s_wdata"}, s_wdata, 0);
    check({tag, "_s_we"}, s_we, 0);
    check({tag, "_s_be"}, s_be, 0);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      m_req_valid[i]        = pv[i];
      m_addr[i*AW +: AW]    = pa[i];
      m_wdata[i*DW +: DW]   = pw[i];
      m_we[i]               = pwe[i];
      m_be[i*BW +: BW]      = pbe[i];
    end
  endtask

  task automatic new_req(input int m, input bit valid);
    pv[m]  = valid;
    pa[m]  = $urandom & 32'hFFFF_FFFC;
    pw[m]  = $urandom;
    pwe[m] = 1'($urandom_range(0, 1));
    pbe[m] = 4'($urandom_range(0, 15));
  endtask

  // Round-robin arbiter model: prefer the master that did not win last.
  function automatic int pick();
    int other = 1 - last_grant;
    if (pv[other]) return other;
    return last_grant;
  endfunction

  task automatic arb_phase(output int w);
    w = pick();
    arb_sel = 1'(w);
    drive_masters();
    @(negedge clk);
    check("idle_state", 64'(dbg_state), 64'(IDLE));
    check("arb_list", arb_valid_list, {pv[1], pv[0]});
    check("req_ready", m_req_ready, 64'd1 << w);
    check("s_valid_idle", s_req_valid, 0);
    check_quiet_rsp("idle");
    exp_q.push_back({pa[w], pw[w], pwe[w], pbe[w]});
    last_grant = w;
    @(posedge clk); #1;
  endtask

  task automatic req_phase(input int stall);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          ewe;
    logic [BW-1:0] ebe;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    {ea, ew, ewe, ebe} = exp_q.pop_front();
    for (int c = 0; c <= stall; c++) begin
      s_req_ready = (c == stall);
      @(negedge clk);
      check("s_req_valid", s_req_valid, 1);
      check("s_addr", s_addr, ea);
      check("s_wdata", s_wdata, ew);
      check("s_we", s_we, ewe);
      check("s_be", s_be, ebe);
      check("req_ready_busy", m_req_ready, 0);
      check("arb_list_busy", arb_valid_list, 0);
      check_quiet_rsp("req");
      @(posedge clk); #1;
    end
    s_req_ready = 1'b0;
  endtask

  // rdelay: RESP cycle carrying the slave response (0 = never arrives).
  task automatic resp_phase(input int w, input int rdelay, input logic [DW-1:0] rdata, input logic rerr);
    bit timed_out = 0;
    bit sent;
    for (int k = 1; k <= T; k++) begin
      s_rsp_valid = (k == rdelay);
      s_rdata     = (k == rdelay) ? rdata : $urandom;
      s_err       = (k == rdelay) ? rerr : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("arb_list_resp", arb_valid_list, 0);
      check("s_valid_resp", s_req_valid, 0);
      check("req_ready_resp", m_req_ready, 0);
      if (k == rdelay) begin
        check("rsp_valid", m_rsp_valid, 64'd1 << w);
        check("rsp_rdata", m_rdata, rdata);
        check("rsp_err", m_err, rerr);
      end else if (k == T) begin
        check("to_valid", m_rsp_valid, 64'd1 << w);
        check("to_rdata", m_rdata, 0);
        check("to_err", m_err, 1);
        timed_out = 1;
      end else begin
        check_quiet_rsp("wait");
      end
      sent = s_rsp_valid;
      @(posedge clk); #1;
      if (sent || timed_out) break;
    end
    s_rsp_valid = 1'b0;
    if (timed_out) begin
      check("flush_state", 64'(dbg_state), 64'(FLUSH));
      for (int f = 1; f <= T; f++) begin
        s_rsp_valid = (rdelay > T) && (f == rdelay - T);
        s_rdata     = $urandom;
        s_err       = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_quiet_rsp("flush");
        check("arb_list_flush", arb_valid_list, 0);
        sent = s_rsp_valid;
        @(posedge clk); #1;
        if (sent) break;
      end
      s_rsp_valid = 1'b0;
    end
    check("back_idle", 64'(dbg_state), 64'(IDLE));
  endtask

  // refill: 0/1 sets the winner's next valid, 2 makes it random.
  task automatic run_txn(input int stall, input int rdelay, input logic [DW-1:0] rdata,
                         input logic rerr, input int refill);
    int w;
    arb_phase(w);
    new_req(w, (refill == 2) ? bit'($urandom_range(0, 1)) : bit'(refill));
    drive_masters();
    arb_sel = 1'($urandom_range(0, 1));
    req_phase(stall);
    resp_phase(w, rdelay, rdata, rerr);
  endtask

  task automatic reset_mid_resp();
    int w;
    arb_phase(w);
    new_req(w, 1);
    drive_masters();
    req_phase(0);
    @(posedge clk); #3;
    reset_i = 1'b1;
    #1;
    check_all_zero("rst_mid");
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    m_req_valid = '0;
    @(posedge clk); #3;
    reset_i = 1'b0;
    #1;
    check_all_zero("rst_rel");
    run_txn(0, 2, $urandom, 1'b0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r, rd;
    reset_i     = 1'b1;
    m_req_valid = '1;
    m_addr      = '0;
    m_wdata     = '0;
    m_we        = '0;
    m_be        = '0;
    arb_sel     = '0;
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    s_rdata     = '0;
    s_err       = 1'b0;
    for (int i = 0; i < N; i++) new_req(i, 0);
    last_grant = 1;
    #12;
    check_all_zero("reset");
    m_req_valid = '0;
    @(posedge clk); #3;
    reset_i = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
    check("post_reset_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;

    // Single read from master0.
    pv[0] = 1; pa[0] = 32'h1000; pw[0] = '0; pwe[0] = 0; pbe[0] = 4'hF;
    run_txn(0, 3, 32'hDEADBEEF, 1'b0, 0);

    // Both masters continuously requesting: grants alternate 1,0,1,0.
    new_req(0, 1);
    new_req(1, 1);
    last_grant = 0;
    for (int i = 0; i < 4; i++) run_txn(0, $urandom_range(1, 6), $urandom, 1'b0, 1);

    // Backpressure on a write from master1 while master0 waits.
    pa[1] = 32'h0000_2040; pw[1] = 32'hCAFEF00D; pwe[1] = 1; pbe[1] = 4'hF;
    run_txn(5, 2, $urandom, 1'b0, 1);

    // Timeout, late response swallowed in FLUSH, then a normal error response.
    run_txn(0, 12, $urandom, 1'b0, 1);
    run_txn(1, 4, $urandom, 1'b1, 1);

    // Response lands exactly on the expiry cycle.
    run_txn(0, T, 32'h1234_5678, 1'b0, 1);

    reset_mid_resp();

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      if (!(pv[0] || pv[1])) begin
        drive_masters();
        arb_sel = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("none_arb_list", arb_valid_list, 0);
        check("none_req_ready", m_req_ready, 0);
        check("none_s_valid", s_req_valid, 0);
        @(posedge clk); #1;
        new_req($urandom_range(0, 1), 1);
        continue;
      end
      r = $urandom_range(0, 9);
      if (r <= 5)      rd = $urandom_range(1, T);
      else if (r <= 7) rd = $urandom_range(T + 1, 2 * T);
      else if (r == 8) rd = 0;
      else             rd = T;
      run_txn($urandom_range(0, 3), rd, $urandom, 1'($urandom_range(0, 1)), 2);
      if ($urandom_range(0, 3) == 0) new_req(1 - last_grant, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
